// File: rtl/spad_read_streamer_if.sv
// Valid/ready beat stream carrying scratchpad words to the consumer.
// Ports: valid, ready, data[DATA_WIDTH], last; master = producer side.
interface spad_read_streamer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );
endinterface

// File: rtl/spad_read_streamer.sv
// Strided scratchpad reader streaming words out with valid/ready/last.
// Ports: clk, rstn, start/base/len/stride, busy/done/err, mem_* read port,
//   out (stream master). Optional macro SPAD_RD_WRAP_EN: circular addressing.
module spad_read_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [ADDR_WIDTH-1:0] stride,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_chip_en,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  spad_read_streamer_if.master  out
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] DEPTH_A = AW1'(DEPTH);
  localparam logic [AW1-1:0] ONE = AW1'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state;

  logic [AW1-1:0]        len_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [AW1-1:0]        issued;
  logic [AW1-1:0]        popped;
  logic                  pending;

  logic [DATA_WIDTH-1:0] fifo [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            cnt;

  logic                  pop;
  logic                  room;
  logic [1:0]            cnt_nx;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  range_bad;
  logic                  bad;

  assign mem_chip_en = busy;

  assign out.valid = (cnt != 2'd0);
  assign out.data  = fifo[rd_ptr];
  assign out.last  = out.valid && (popped == len_q - ONE);

  assign pop = out.valid && out.ready;

  // Slots are counted as stored words plus the read still in flight.
  assign room = (cnt == 2'd0) || ((cnt == 2'd1) && !pending);

  assign mem_ren = (state == RUN) && (issued != len_q) && (room || pop);

  // Between issues the port keeps showing the last address read.
  assign mem_raddr = mem_ren ? cur_addr : raddr_q;

  assign cnt_nx = cnt + {1'b0, pending} - {1'b0, pop};

`ifdef SPAD_RD_WRAP_EN
  logic [AW1-1:0] sum;

  assign sum = {1'b0, cur_addr} + {1'b0, stride_q};

  // stride < DEPTH keeps the sum below 2*DEPTH, so one subtract suffices.
  assign next_addr = ADDR_WIDTH'((sum >= DEPTH_A) ? (sum - DEPTH_A) : sum);

  assign range_bad = 1'b0;
`else
  localparam int PW = 2 * ADDR_WIDTH + 2;

  logic [PW-1:0] span;

  assign next_addr = cur_addr + stride_q;

  assign span = PW'(base) + (PW'(len - ONE) * PW'(stride));

  assign range_bad = (len != '0) && (span > PW'(DEPTH - 1));
`endif

  assign bad = ({1'b0, stride} >= DEPTH_A)
            || (len > DEPTH_A)
            || range_bad;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      len_q    <= '0;
      stride_q <= '0;
      cur_addr <= '0;
      raddr_q  <= '0;
      issued   <= '0;
      popped   <= '0;
      pending  <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      cnt      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo[i] <= '0;
      end
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      pending <= mem_ren;
      cnt     <= cnt_nx;

      if (mem_ren) begin
        raddr_q  <= cur_addr;
        cur_addr <= next_addr;
        issued   <= issued + ONE;
      end

      // Data for the read issued last cycle is on mem_dout now.
      if (pending) begin
        fifo[wr_ptr] <= mem_dout;
        wr_ptr       <= ~wr_ptr;
      end

      if (pop) begin
        rd_ptr <= ~rd_ptr;
        popped <= popped + ONE;
      end

      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len;
            stride_q <= stride;
            cur_addr <= base;
            issued   <= '0;
            popped   <= '0;
            if (bad) begin
              err <= 1'b1;
            end else if (len == '0) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (mem_ren && (issued + ONE == len_q)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_nx == 2'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spad_read_streamer.sv
// Bench for spad_read_streamer: vector table, scoreboard, corner sequences.
// Honors SPAD_RD_WRAP_EN for the expected range-check behaviour.
module tb_spad_read_streamer;

  localparam int DW = 8;
  localparam int D  = 16;
  localparam int AW = 4;

`ifdef SPAD_RD_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic [AW-1:0] stride = '0;
  logic          busy;
  logic          done;
  logic          err;
  logic          mem_chip_en;
  logic          mem_ren;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_dout = '0;

  spad_read_streamer_if #(.DATA_WIDTH(DW)) sif ();

  spad_read_streamer #(
    .DATA_WIDTH(DW),
    .DEPTH(D),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .base(base),
    .len(len),
    .stride(stride),
    .busy(busy),
    .done(done),
    .err(err),
    .mem_chip_en(mem_chip_en),
    .mem_ren(mem_ren),
    .mem_raddr(mem_raddr),
    .mem_dout(mem_dout),
    .out(sif)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [D];

  always @(posedge clk) begin
    if (mem_chip_en && mem_ren) mem_dout <= mem[mem_raddr];
  end

  int total = 0;
  int bad = 0;
  int beats = 0;
  int outstanding = 0;
  int rmode = 0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic prev_last;

  logic [DW:0]   exp_q [$];
  logic [AW-1:0] addr_q [$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Independent reference: integer range check and modulo addressing.
  task automatic sb_push(input int b, input int l, input int s);
    int a;
    if (s >= D || l > D) return;
    if (!WRAP && l > 0 && b + (l - 1) * s > D - 1) return;
    a = b;
    for (int k = 0; k < l; k++) begin
      addr_q.push_back(AW'(a));
      exp_q.push_back({(k == l - 1), mem[a]});
      a = (a + s) % D;
    end
  endtask

  initial begin
    sif.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: sif.ready = 1'b1;
        1: sif.ready = ~sif.ready;
        default: sif.ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    logic [DW:0] e;
    if (!rstn) begin
      outstanding = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", sif.valid, 1);
        check("hold_data", sif.data, prev_data);
        check("hold_last", sif.last, prev_last);
      end
      if (sif.valid && sif.ready) begin
        outstanding--;
        beats++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_extra: got %0h want none", sif.data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", sif.data, e[DW-1:0]);
          check("beat_last", sif.last, e[DW]);
        end
      end
      if (mem_ren) begin
        outstanding++;
        if (addr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL raddr_extra: got %0d want none", mem_raddr);
        end else begin
          check("raddr", mem_raddr, addr_q.pop_front());
        end
        check("occupancy_le2", outstanding <= 2, 1);
      end
      prev_stall = sif.valid && !sif.ready;
      prev_data = sif.data;
      prev_last = sif.last;
    end
  end

  typedef struct {
    int b;
    int l;
    int s;
    int mode;
    int kind;
    int nbeats;
  } vec_t;

  vec_t vecs [11];

  task automatic run_vec(input vec_t v, input string nm);
    int b0;
    int lat;
    bit se, sd, sr, sv, sb, fin;
    se = 0; sd = 0; sr = 0; sv = 0; sb = 0; fin = 0;
    rmode = v.mode;
    b0 = beats;
    sb_push(v.b, v.l, v.s);
    @(posedge clk);
    #1;
    start = 1'b1;
    base = AW'(v.b);
    len = (AW+1)'(v.l);
    stride = AW'(v.s);
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!fin && lat < 300) begin
      @(negedge clk);
      lat++;
      if (err) se = 1;
      if (done) sd = 1;
      if (mem_ren) sr = 1;
      if (sif.valid) sv = 1;
      if (busy) sb = 1;
      if (done || err) fin = 1;
    end
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done/err want done or err", nm);
    end
    repeat (2) @(posedge clk);
    check({nm, "_err"}, se, v.kind == 1);
    check({nm, "_done"}, sd, v.kind != 1);
    check({nm, "_beats"}, beats - b0, v.nbeats);
    check({nm, "_ren"}, sr, v.nbeats != 0);
    check({nm, "_valid"}, sv, v.nbeats != 0);
    check({nm, "_busy"}, sb, v.kind == 0);
    check({nm, "_sb_empty"}, exp_q.size(), 0);
    if (v.kind != 0) check({nm, "_lat"}, lat, 1);
    rmode = 0;
  endtask

  initial begin
    int b0;
    int nd;
    int ne;
    bit got;
    for (int i = 0; i < D; i++) mem[i] = 8'h10 + 8'(i);

    vecs[0]  = '{2, 4, 1, 0, 0, 4};
    vecs[1]  = '{1, 3, 5, 0, 0, 3};
    vecs[2]  = '{4, 8, 1, 1, 0, 8};
    vecs[3]  = WRAP ? '{14, 4, 1, 0, 0, 4} : '{14, 4, 1, 0, 1, 0};
    vecs[4]  = '{3, 0, 1, 0, 2, 0};
    vecs[5]  = '{0, 17, 1, 0, 1, 0};
    vecs[6]  = '{0, 16, 1, 2, 0, 16};
    vecs[7]  = '{3, 4, 4, 1, 0, 4};
    vecs[8]  = WRAP ? '{4, 4, 4, 0, 0, 4} : '{4, 4, 4, 0, 1, 0};
    vecs[9]  = '{2, 5, 3, 2, 0, 5};
    vecs[10] = '{15, 1, 0, 1, 0, 1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", sif.valid, 0);
    check("rst_ren", mem_ren, 0);
    check("rst_chip_en", mem_chip_en, 0);
    check("rst_done", done, 0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Cycle-exact basic stream.
    sb_push(2, 4, 1);
    #1;
    start = 1'b1; base = 4'd2; len = 5'd4; stride = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t_busy", busy, 1);
    check("t_ren", mem_ren, 1);
    check("t_addr0", mem_raddr, 2);
    @(posedge clk);
    #1;
    check("t_novalid", sif.valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("t_valid", sif.valid, 1);
      check("t_data", sif.data, 8'h12 + 8'(k));
      check("t_last", sif.last, k == 3);
    end
    @(posedge clk);
    #1;
    check("t_done", done, 1);
    check("t_busy_fall", busy, 0);
    check("t_valid_off", sif.valid, 0);
    @(posedge clk);
    #1;
    check("t_done_pulse", done, 0);

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Start while busy must be ignored.
    rmode = 0;
    b0 = beats;
    sb_push(0, 6, 2);
    @(posedge clk);
    #1;
    start = 1'b1; base = 4'd0; len = 5'd6; stride = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; base = 4'd5; len = 5'd3; stride = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nd = 0;
    ne = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (err) ne++;
    end
    check("bs_done", nd, 1);
    check("bs_err", ne, 0);
    check("bs_beats", beats - b0, 6);
    check("bs_sb_empty", exp_q.size(), 0);

    // Reset in the middle of a stream.
    b0 = beats;
    sb_push(3, 8, 1);
    @(posedge clk);
    #1;
    start = 1'b1; base = 4'd3; len = 5'd8; stride = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk);
      #1;
      if (beats - b0 >= 2) got = 1;
    end
    check("mr_two_beats", got, 1);
    rstn = 1'b0;
    exp_q.delete();
    addr_q.delete();
    #1;
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_err", err, 0);
    check("mr_chip_en", mem_chip_en, 0);
    check("mr_ren", mem_ren, 0);
    check("mr_raddr", mem_raddr, 0);
    check("mr_valid", sif.valid, 0);
    check("mr_data", sif.data, 0);
    check("mr_last", sif.last, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    run_vec('{0, 2, 1, 0, 0, 2}, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
